// File: rtl/fb_arbiter.sv
// Framebuffer RAM arbiter: fixed-latency display reads with strict priority, camera writes
// buffered in a FIFO and drained into idle RAM cycles. Define FB_ARB_ERR_CNT_EN to build err_cnt_o.
module fb_arbiter #(
    parameter int ADDR_WIDTH_g  = 19,
    parameter int DATA_WIDTH_g  = 12,
    parameter int FB_WORDS_g    = 307200,
    parameter int WFIFO_DEPTH_g = 8,
    parameter int RD_LATENCY_g  = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              rd_req_i,
    input  logic [ADDR_WIDTH_g-1:0]           rd_addr_i,
    output logic [DATA_WIDTH_g-1:0]           rd_data_o,
    output logic                              rd_valid_o,
    input  logic                              wr_valid_i,
    output logic                              wr_ready_o,
    input  logic [ADDR_WIDTH_g-1:0]           wr_addr_i,
    input  logic [DATA_WIDTH_g-1:0]           wr_data_i,
    input  logic                              flush_i,
    output logic                              mem_en_o,
    output logic                              mem_we_o,
    output logic [ADDR_WIDTH_g-1:0]           mem_addr_o,
    output logic [DATA_WIDTH_g-1:0]           mem_wdata_o,
    input  logic [DATA_WIDTH_g-1:0]           mem_rdata_i,
    output logic [$clog2(WFIFO_DEPTH_g):0]    wfifo_level_o,
    output logic                              err_o,
    output logic [15:0]                       err_cnt_o
);

    localparam int PTR_W   = $clog2(WFIFO_DEPTH_g);
    localparam int LVL_W   = PTR_W + 1;
    localparam int VPIPE_W = RD_LATENCY_g + 1;
    localparam logic [ADDR_WIDTH_g:0] FB_LIMIT  = (ADDR_WIDTH_g+1)'(FB_WORDS_g);
    localparam logic [LVL_W-1:0]      DEPTH_LVL = LVL_W'(WFIFO_DEPTH_g);

    // State bits double as the registered RAM strobes: [1]=enable, [0]=write.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b10,
        ST_WR   = 2'b11
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;

    logic [ADDR_WIDTH_g-1:0]  r_fifo_addr [WFIFO_DEPTH_g];
    logic [DATA_WIDTH_g-1:0]  r_fifo_data [WFIFO_DEPTH_g];
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [LVL_W-1:0]         r_level;
    logic [LVL_W-1:0]         w_level_next;
    logic                     r_ready;

    logic                     w_push;
    logic                     w_pop;
    logic [ADDR_WIDTH_g-1:0]  w_head_addr;
    logic [DATA_WIDTH_g-1:0]  w_head_data;
    logic                     w_head_oor;
    logic                     w_rd_oor;
    logic                     w_rd_hit;
    logic                     w_wr_in_oor;

    logic [ADDR_WIDTH_g-1:0]  r_mem_addr;
    logic [DATA_WIDTH_g-1:0]  r_mem_wdata;

    logic [VPIPE_W-1:0]       r_vpipe;
    logic [VPIPE_W-1:0]       r_opipe;
    logic [VPIPE_W-1:0]       w_vpipe_next;
    logic [VPIPE_W-1:0]       w_opipe_next;
    logic                     r_rd_valid;
    logic [DATA_WIDTH_g-1:0]  r_rd_data;
    logic                     r_err;

    assign w_head_addr = r_fifo_addr[r_rd_ptr];
    assign w_head_data = r_fifo_data[r_rd_ptr];
    assign w_head_oor  = ({1'b0, w_head_addr} >= FB_LIMIT);
    assign w_rd_oor    = rd_req_i && ({1'b0, rd_addr_i} >= FB_LIMIT);
    assign w_rd_hit    = rd_req_i && !w_rd_oor;

    // Flush discards a simultaneous push; ready alone gates pushes, so full never accepts.
    assign w_push      = wr_valid_i && r_ready && !flush_i;
    assign w_wr_in_oor = w_push && ({1'b0, wr_addr_i} >= FB_LIMIT);

    // Arbitration: an in-range read owns the RAM; an out-of-range read leaves the slot to writes.
    always_comb begin
        w_state_next = ST_IDLE;
        w_pop        = 1'b0;
        if (w_rd_hit) begin
            w_state_next = ST_RD;
        end else if ((r_level != '0) && !flush_i) begin
            w_pop = 1'b1;
            if (!w_head_oor) begin
                w_state_next = ST_WR;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state <= w_state_next;
            case (w_state_next)
                ST_RD: begin
                    r_mem_addr <= rd_addr_i;
                end
                ST_WR: begin
                    r_mem_addr  <= w_head_addr;
                    r_mem_wdata <= w_head_data;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_level_next = r_level;
        if (flush_i) begin
            w_level_next = '0;
        end else if (w_push && !w_pop) begin
            w_level_next = r_level + LVL_W'(1);
        end else if (!w_push && w_pop) begin
            w_level_next = r_level - LVL_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ready  <= 1'b1;
        end else begin
            if (flush_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
            end
            r_level <= w_level_next;
            r_ready <= (w_level_next != DEPTH_LVL);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= wr_addr_i;
            r_fifo_data[r_wr_ptr] <= wr_data_i;
        end
    end

    // Read-valid and out-of-range flags travel together so the response slot stays fixed.
    assign w_vpipe_next[0] = rd_req_i;
    assign w_opipe_next[0] = w_rd_oor;
    generate
        for (genvar gi = 1; gi < VPIPE_W; gi++) begin : g_vpipe
            assign w_vpipe_next[gi] = r_vpipe[gi-1];
            assign w_opipe_next[gi] = r_opipe[gi-1];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vpipe    <= '0;
            r_opipe    <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_vpipe    <= w_vpipe_next;
            r_opipe    <= w_opipe_next;
            r_rd_valid <= r_vpipe[RD_LATENCY_g];
            r_rd_data  <= (r_vpipe[RD_LATENCY_g] && !r_opipe[RD_LATENCY_g]) ? mem_rdata_i : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if (w_rd_oor || w_wr_in_oor) begin
            r_err <= 1'b1;
        end
    end

`ifdef FB_ARB_ERR_CNT_EN
    logic [15:0] r_err_cnt;
    logic [16:0] w_err_sum;

    // A read and a write can both be out of range in one cycle, hence the two-term sum.
    assign w_err_sum = {1'b0, r_err_cnt} + 17'(w_rd_oor) + 17'(w_wr_in_oor);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err_cnt <= '0;
        end else begin
            r_err_cnt <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
        end
    end

    assign err_cnt_o = r_err_cnt;
`else
    assign err_cnt_o = '0;
`endif

    assign mem_en_o      = r_state[1];
    assign mem_we_o      = r_state[0];
    assign mem_addr_o    = r_mem_addr;
    assign mem_wdata_o   = r_mem_wdata;
    assign rd_valid_o    = r_rd_valid;
    assign rd_data_o     = r_rd_data;
    assign wr_ready_o    = r_ready;
    assign wfifo_level_o = r_level;
    assign err_o         = r_err;

endmodule
